shift_seq_stage: RTL and testbench

Sequential shift stage directly downstream of the operand source that drives the combinational shift operator; it performs the same shift family over multiple cycles. It captures one operand, shift amount and opcode with a valid/ready handshake. It shifts one bit position per clock and presents a registered result with a valid/ready handshake. It is the multi-cycle, area-light counterpart used where the combinational shifter's depth is not acceptable.

---
 rtl/shift_seq_stage_if.sv | 26 ++
 rtl/shift_seq_stage.sv | 150 +++++++++++++++
 tb/tb_shift_seq_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/shift_seq_stage_if.sv
// Operand/result handshake bundle for the sequential shift stage.
// The master side is upstream/downstream logic; the slave side is the stage itself.
interface shift_seq_stage_if #(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_op;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               busy;

   modport master (
      output in_valid, in_data, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/shift_seq_stage.sv
// Multi-cycle LSL/LSR/ASR/ROL shifter: captures one operand, shifts one bit per clock,
// then holds the registered result until the downstream side takes it.
module shift_seq_stage #(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   shift_seq_stage_if.slave  ss_if
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int CMP_W = (SHAMT_W > CNT_W) ? SHAMT_W : CNT_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROL = 2'b11
   } op_e;

   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d, input op_e op);
      logic [WIDTH-1:0] r;
      r = d;
      case (op)
         OP_LSL:  r = {d[WIDTH-2:0], 1'b0};
         OP_LSR:  r = {1'b0, d[WIDTH-1:1]};
         OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
         OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
         default: r = d;
      endcase
      return r;
   endfunction

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;

   logic               in_ready_s;
   logic               accept_s;
   logic [CMP_W-1:0]   shamt_ext_s;
   logic [CNT_W-1:0]   n_s;
   logic [WIDTH-1:0]   step_s;

   // Ready depends only on registered state, and is forced low while reset is held.
   assign in_ready_s = (state_q == ST_IDLE) && rst_n;
   assign accept_s   = ss_if.in_valid && in_ready_s;

   // Effective step count: logical/arithmetic shifts saturate at WIDTH, rotates wrap.
   always_comb begin
      shamt_ext_s = CMP_W'(ss_if.in_shamt);
      n_s         = {CNT_W{1'b0}};
      if (op_e'(ss_if.in_op) == OP_ROL) begin
         n_s = CNT_W'(shamt_ext_s & CMP_W'(WIDTH - 1));
      end else if (shamt_ext_s >= CMP_W'(WIDTH)) begin
         n_s = CNT_W'(WIDTH);
      end else begin
         n_s = CNT_W'(shamt_ext_s);
      end
   end

   assign step_s = step1(data_q, op_q);

   // Next-state, datapath and result update.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               data_d = ss_if.in_data;
               op_d   = op_e'(ss_if.in_op);
               cnt_d  = n_s;
               if (n_s != {CNT_W{1'b0}}) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = ss_if.in_data;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            data_d = step_s;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               out_data_d  = step_s;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            // No bypass: the stage always passes through IDLE before a new capture.
            if (ss_if.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LSL;
         data_q      <= {WIDTH{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign ss_if.in_ready  = in_ready_s;
   assign ss_if.out_valid = out_valid_q;
   assign ss_if.out_data  = out_data_q;
   assign ss_if.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_stage.sv
// Bench for shift_seq_stage: directed cases then random operations scored against
// an arithmetic reference of the shift rules.
module tb_shift_seq_stage;
   localparam int W  = 4;
   localparam int SW = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   shift_seq_stage_if #(.WIDTH(W), .SHAMT_W(SW)) sif ();

   shift_seq_stage #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ss_if (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_n(input int sh, input int op);
      if (op == 3) return sh % W;
      return (sh >= W) ? W : sh;
   endfunction

   function automatic logic [31:0] ref_result(input int d, input int sh, input int op);
      int mask;
      int sd;
      int r;
      mask = (1 << W) - 1;
      case (op)
         0: return (sh >= W) ? 0 : ((d << sh) & mask);
         1: return (sh >= W) ? 0 : (d >> sh);
         2: begin
            sd = (d >= (1 << (W - 1))) ? d - (1 << W) : d;
            return (sd >>> ((sh >= W) ? W : sh)) & mask;
         end
         default: begin
            r = sh % W;
            return ((d << r) | (d >> (W - r))) & mask;
         end
      endcase
   endfunction

   // One full transaction: accept, measure latency, optional stall with junk on the input side, handshake.
   task automatic do_op(input int d, input int sh, input int op, input int stall, input string tag);
      int          lat;
      logic [31:0] exp;
      exp = ref_result(d, sh, op);
      chk({tag, "_rdy_before"}, 32'(sif.in_ready), 32'd1);
      sif.in_valid  = 1'b1;
      sif.in_data   = W'(d);
      sif.in_shamt  = SW'(sh);
      sif.in_op     = 2'(op);
      sif.out_ready = 1'b0;
      @(posedge clk); #1;
      lat = 1;
      sif.in_valid = 1'b0;
      sif.in_data  = 'x;
      sif.in_shamt = 'x;
      sif.in_op    = 'x;
      while (sif.out_valid !== 1'b1 && lat < W + 4) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(1 + ref_n(sh, op)));
      chk({tag, "_data"}, 32'(sif.out_data), exp);
      chk({tag, "_busy"}, 32'(sif.busy), 32'd1);
      chk({tag, "_rdy_done"}, 32'(sif.in_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         sif.in_valid = (i % 2 == 0);
         sif.in_data  = W'($urandom);
         sif.in_shamt = SW'($urandom);
         sif.in_op    = 2'($urandom);
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, 32'(sif.out_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(sif.out_data), exp);
         chk({tag, "_hold_rdy"}, 32'(sif.in_ready), 32'd0);
      end
      sif.out_ready = 1'b1;
      sif.in_valid  = 1'b1;
      sif.in_data   = W'($urandom);
      sif.in_shamt  = SW'(0);
      sif.in_op     = 2'(0);
      @(posedge clk); #1;
      chk({tag, "_post_valid"}, 32'(sif.out_valid), 32'd0);
      chk({tag, "_post_rdy"}, 32'(sif.in_ready), 32'd1);
      chk({tag, "_no_bypass"}, 32'(sif.busy), 32'd0);
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.in_shamt  = '0;
      sif.in_op     = '0;
      sif.out_ready = 1'b0;
      #2;
      chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
      chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
      chk("rst_out_data", 32'(sif.out_data), 32'd0);
      chk("rst_busy", 32'(sif.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(sif.in_ready), 32'd1);

      do_op(4'b1100, 1, 0, 0, "t1_lsl");
      do_op(4'b1110, 2, 2, 0, "t2_asr_neg");
      do_op(4'b0110, 2, 2, 0, "t2_asr_pos");
      do_op(4'b0010, 11, 1, 0, "t3_lsr_sat");
      do_op(4'b1011, 5, 3, 0, "t3_rol_wrap");
      do_op(4'b1000, 15, 2, 0, "t3_asr_sat");
      do_op(4'b1011, 4, 3, 0, "t3_rol_w");
      do_op(4'b1010, 0, 0, 0, "t4_zero_lsl");
      do_op(4'b1010, 0, 1, 0, "t4_zero_lsr");
      do_op(4'b1010, 0, 2, 0, "t4_zero_asr");
      do_op(4'b1010, 0, 3, 0, "t4_zero_rol");
      do_op(4'b0011, 1, 0, 3, "t5_backpressure");
      do_op(4'b0101, 3, 3, 0, "t5_next");

      sif.in_valid = 1'b1;
      sif.in_data  = 4'b1111;
      sif.in_shamt = 4'd3;
      sif.in_op    = 2'b01;
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 32'(sif.out_valid), 32'd0);
      chk("t6_rst_out_data", 32'(sif.out_data), 32'd0);
      chk("t6_rst_busy", 32'(sif.busy), 32'd0);
      chk("t6_rst_in_ready", 32'(sif.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t6_rel_in_ready", 32'(sif.in_ready), 32'd1);
      chk("t6_rel_busy", 32'(sif.busy), 32'd0);
      do_op(4'b0001, 2, 0, 0, "t6_fresh");

      for (int k = 0; k < 40; k++) begin
         do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
